mem_responder: RTL

Behavioural main-memory responder on the memory side of the cache-to-memory interface. Serves whole-block line fills (reads) and dirty-block writebacks (writes) issued by the cache control unit. It provides a fixed, configurable access latency and moves each block as a burst of MEM_WIDTH-bit beats. It is used as the memory model in cache-level simulation and as the reference for the future memory controller.

---
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Behavioural main-memory responder for the cache-to-memory interface.
// Serves whole-block line fills and dirty-block writebacks with a fixed
// access latency, moving each block as a burst of MEM_WIDTH-bit beats.
// Storage is an inferred RAM with a registered read port and no reset, so
// its contents survive reset; control state resets asynchronously.
module mem_responder #(
    parameter int BYTE      = 8,
    parameter int BLK_SIZE  = 64,
    parameter int PA_WIDTH  = 32,
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 4096,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_we,
    input  logic [PA_WIDTH-1:0]  mem_req_addr,
    input  logic                 mem_wr_valid,
    input  logic [MEM_WIDTH-1:0] mem_wr_data,
    output logic                 mem_wr_ready,
    output logic                 mem_wr_done,
    output logic                 mem_rd_valid,
    output logic [MEM_WIDTH-1:0] mem_rd_data,
    output logic                 mem_rd_last,
    output logic                 mem_busy
);

    localparam int BEATS = BLK_SIZE * BYTE / MEM_WIDTH;
    localparam int WB    = $clog2(MEM_WIDTH / BYTE);
    localparam int BB    = $clog2(BLK_SIZE);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [7:0]    LAT_LAST  = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);
    localparam bit            LAT_ZERO  = (LATENCY == 0);
    // Clears the word-within-block bits so every burst starts at word 0 of the block.
    localparam logic [AW-1:0] BASE_MASK = ~((AW'(1) << (BB - WB)) - AW'(1));

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_DATA  = 3'd3,
        WR_WAIT  = 3'd4,
        WR_ACK   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [7:0]     wait_q, wait_d;
    logic [AW-1:0]  base_q, base_d;
    logic [AW-1:0]  req_base;

    logic           req_ready_q;
    logic           busy_q;
    logic           wr_ready_q;
    logic           wr_done_q;
    logic           rd_valid_q;
    logic           rd_last_q;
    logic [MEM_WIDTH-1:0] rd_word_q;

    logic [MEM_WIDTH-1:0] mem_array [MEM_DEPTH];
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;

    // Word address of the block base; the truncation to AW bits is the wrap modulo MEM_DEPTH.
    assign req_base = AW'(mem_req_addr >> WB) & BASE_MASK;

    // Next-state logic: request acceptance, latency countdown and beat counting.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    base_d = req_base;
                    beat_d = '0;
                    wait_d = '0;
                    if (mem_req_we)
                        state_d = WR_DATA;
                    else if (LAT_ZERO)
                        state_d = RD_BURST;
                    else
                        state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    wait_d  = '0;
                    state_d = RD_BURST;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RD_BURST: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            WR_DATA: begin
                if (mem_wr_valid) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = LAT_ZERO ? WR_ACK : WR_WAIT;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            WR_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    wait_d  = '0;
                    state_d = WR_ACK;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with outputs decoded from the next state so they are flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            base_q      <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            base_q      <= base_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            wr_ready_q  <= (state_d == WR_DATA);
            wr_done_q   <= (state_d == WR_ACK);
            rd_valid_q  <= (state_d == RD_BURST);
            rd_last_q   <= (state_d == RD_BURST) && (beat_d == BEAT_LAST);
        end
    end

    // Writes land at base + beat; the read port fetches the word the next cycle will present.
    assign wr_en   = (state_q == WR_DATA) && mem_wr_valid;
    assign wr_addr = base_q + AW'(beat_q);
    assign rd_addr = base_d + AW'(beat_d);

    // Block RAM: one write port, one registered read port, contents never reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_array[wr_addr] <= mem_wr_data;
        rd_word_q <= mem_array[rd_addr];
    end

    assign mem_req_ready = req_ready_q;
    assign mem_busy      = busy_q;
    assign mem_wr_ready  = wr_ready_q;
    assign mem_wr_done   = wr_done_q;
    assign mem_rd_valid  = rd_valid_q;
    assign mem_rd_last   = rd_last_q;
    // Fill data is forced to zero outside valid beats; an async reset clears it at once.
    assign mem_rd_data   = rd_valid_q ? rd_word_q : '0;

endmodule
